fp_log_lut_pipe: RTL and testbench
==================================

FP_LOG_LUT_PIPE -- requirements
Module: fp_log_lut_pipe

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 8, as the LUT index width; table depth is DEPTH = 2^ADDR_WIDTH.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 16, as the entry width (fp16: 1 sign, 5 exponent, 10 mantissa).
REQ-003 The block SHALL take parameter NUM_CH, default 4, as the number of parallel lookup channels sharing one table.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 load_start  in  1  one-cycle pulse; begins a full table (re)load.
REQ-008 load_valid  in  1  load_data carries the next table entry.
REQ-009 load_data  in  DATA_WIDTH  table entry, written in ascending index order.
REQ-010 table_ready  out  1  high when the table is fully loaded and lookups are accepted.
REQ-011 in_valid  in  1  lookup request valid.
REQ-012 in_ready  out  1  lookup request accepted when high together with in_valid.
REQ-013 in_addr  in  NUM_CH*ADDR_WIDTH  per-channel index; channel k is bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-014 out_valid  out  1  out_data is valid.
REQ-015 out_ready  in  1  downstream accepts out_data.
REQ-016 out_data  out  NUM_CH*DATA_WIDTH  per-channel table[in_addr_k], same channel packing as in_addr.

Function
REQ-017 The control FSM SHALL have three states: IDLE (no valid table), LOAD, and RUN.
REQ-018 In IDLE, load_start SHALL move the FSM to LOAD and clear load counter cnt to 0.
REQ-019 In LOAD, each cycle with load_valid=1 SHALL write load_data to table[cnt] and increment cnt.
REQ-020 In LOAD, the write at cnt==DEPTH-1 SHALL move the FSM to RUN on the next edge; cnt does not wrap.
REQ-021 In LOAD, load_start SHALL restart the load: cnt returns to 0 and the load_valid of that cycle is ignored.
REQ-022 In RUN, load_start SHALL be accepted only when both pipeline stages are empty; otherwise it is ignored, and the caller drains first.
REQ-023 load_valid outside LOAD SHALL be ignored.
REQ-024 table_ready SHALL be 1 exactly when the FSM is in RUN.
REQ-025 The pipeline SHALL have two stages: S1 registers the addresses, S2 registers the table read into out_data.
REQ-026 Advance enable SHALL be en = !out_valid || out_ready.
REQ-027 in_ready SHALL equal table_ready && en; this is a combinational path from out_ready.
REQ-028 When en=1, S1 SHALL capture (in_valid && in_ready, in_addr), and S2 SHALL capture (S1 valid, table lookup of the S1 addresses).
REQ-029 When en=0, both stages SHALL hold and out_data SHALL stay stable while out_valid=1.
REQ-030 Latency from accepted request to out_valid SHALL be 2 cycles with out_ready held high.
REQ-031 With out_ready=1, the block SHALL sustain throughput of 1 request per cycle with no bubbles.
REQ-032 Channels SHALL be independent; identical addresses on several channels SHALL return identical data.
REQ-033 The table SHALL be read as raw bit patterns, with no arithmetic, rounding or saturation.

Reset
REQ-034 Reset SHALL force the FSM to IDLE and set cnt=0, S1 valid=0, out_valid=0, table_ready=0 and in_ready=0.
REQ-035 After reset, out_data SHALL read 0, and table contents are not cleared (a reload is required).
REQ-036 Reset asserted mid-LOAD or with requests in flight SHALL discard them, with no out_valid pulse afterwards.

Verification
REQ-037 Scenario 1: reset, then load table[i]=16'h3000+i for i=0..255, in_addr channels={8'h00,8'h01,8'h7F,8'hFF} -> table_ready=1 after the 256th write; out_data channels={16'h3000,16'h3001,16'h307F,16'h30FF} 2 cycles after acceptance.
REQ-038 Scenario 2: back-to-back requests on 10 cycles with out_ready=1 -> 10 consecutive out_valid cycles starting 2 cycles after the first request, in request order.
REQ-039 Scenario 3: out_ready=0 for 5 cycles with 3 requests offered -> at most 2 accepted, in_ready=0 while stalled, out_data stable, no loss or duplication once out_ready=1.
REQ-040 Scenario 4: load_start after 100 entries, then a full reload with table[i]=16'h1BFC -> every lookup returns 16'h1BFC.
REQ-041 Scenario 5: load_start in RUN with S2 occupied -> ignored, table_ready stays 1; repeated after drain -> table_ready=0 next cycle.
REQ-042 Scenario 6: reset at load entry 50, then in_valid=1 -> in_ready=0 and out_valid=0 until a full new load completes.

Source files
------------

// File: rtl/fp_log_lut_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_log_lut_pipe_if
// Description : Bundle of the table-load, lookup-request and lookup-response
//               signals of fp_log_lut_pipe.
//               master : drives load/request side, accepts responses
//               slave  : the lookup block itself
// Ports       : load_start, load_valid, load_data  -> table (re)load
//               table_ready                        <- table usable
//               in_valid, in_addr / in_ready       -> lookup request
//               out_valid, out_data / out_ready    <- lookup response
// Revision    : 1.0  initial release
// ============================================================================
interface fp_log_lut_pipe_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
);
  logic                           load_start;
  logic                           load_valid;
  logic [DATA_WIDTH-1:0]          load_data;
  logic                           table_ready;
  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0]   in_addr;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]   out_data;

  modport master (
    output load_start, load_valid, load_data,
    output in_valid, in_addr, out_ready,
    input  table_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  load_start, load_valid, load_data,
    input  in_valid, in_addr, out_ready,
    output table_ready, in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fp_log_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_log_lut_pipe
// Description : Loadable lookup table (fp16 entries by default) shared by
//               NUM_CH parallel lookup channels behind a two-stage
//               valid/ready pipeline. The table is filled sequentially
//               from index 0; lookups are only accepted once every entry
//               has been written.
// Ports       : clk    - rising-edge clock
//               reset  - synchronous active-high reset
//               bus    - fp_log_lut_pipe_if.slave (load, request, response)
// Revision    : 1.0  initial release
// ============================================================================
module fp_log_lut_pipe #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4
) (
  input  logic              clk,
  input  logic              reset,
  fp_log_lut_pipe_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  logic [1:0]                   state;
  logic [ADDR_WIDTH-1:0]        cnt;

  // --------------------------------------------------------------------------
  // Table storage and pipeline registers
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]        lut [DEPTH];

  logic                         s1_valid;
  logic [NUM_CH*ADDR_WIDTH-1:0] s1_addr;
  logic                         s2_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] s2_data;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_data;

  logic                         table_ready;
  logic                         en;
  logic                         in_ready;
  logic                         accept;
  logic                         pipe_empty;
  logic                         tbl_wr;

  assign table_ready = (state == ST_RUN);

  // Both stages move together; the whole pipe stalls only when a result is
  // being held for a downstream that is not ready.
  assign en          = !s2_valid || bus.out_ready;
  assign in_ready    = table_ready && en;
  assign accept      = bus.in_valid && in_ready;
  assign pipe_empty  = !s1_valid && !s2_valid;

  // A load_start in LOAD takes priority over the data beat of the same cycle.
  assign tbl_wr      = (state == ST_LOAD) && bus.load_valid && !bus.load_start;

  assign bus.table_ready = table_ready;
  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = s2_data;

  // --------------------------------------------------------------------------
  // Control FSM: IDLE -> LOAD -> RUN, reload possible from RUN once drained
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.load_start) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.load_start) begin
            cnt <= '0;
          end else if (bus.load_valid) begin
            // Final entry completes the table; cnt is left at the last
            // index rather than wrapping.
            if (cnt == LAST_IDX) begin
              state <= ST_RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Reloading under in-flight lookups would corrupt their results,
          // so the request is simply dropped until the pipe is empty.
          if (bus.load_start && pipe_empty) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Table write port. Contents survive reset; a reload is what makes the
  // table valid again.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      lut[cnt] <= bus.load_data;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel read ports, addressed from the S1 register
  // --------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
        lut[s1_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Two-stage pipeline: S1 holds addresses, S2 holds the read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (en) begin
      s1_valid <= accept;
      s1_addr  <= bus.in_addr;
      s2_valid <= s1_valid;
      // Data only moves with a real result, so out_data keeps its last
      // meaningful value (0 after reset) between transactions.
      if (s1_valid) begin
        s2_data <= rd_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_log_lut_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_log_lut_pipe
// Description : Self-checking bench for fp_log_lut_pipe. A behavioural table
//               model plus an expected-result queue is compared against the
//               DUT on every cycle; directed scenarios add literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fp_log_lut_pipe;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_log_lut_pipe_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  fp_log_lut_pipe #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [DW-1:0]      ref_mem [DEPTH];
  logic [NCH*DW-1:0]  exp_q [$];
  bit                 exp_ready = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic logic [NCH*DW-1:0] model_lookup(input logic [NCH*AW-1:0] a);
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = ref_mem[a[k*AW +: AW]];
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Scoreboard: runs at the negedge, i.e. what will happen at the next edge
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      check("table_ready", bus.table_ready, exp_ready);
      check("in_ready", bus.in_ready, exp_ready && (!bus.out_valid || bus.out_ready));
      if (bus.out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid: got out_valid=1 required 0 (no request in flight)");
        end else begin
          check("out_data", bus.out_data, exp_q[0]);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model_lookup(bus.in_addr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    exp_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_table_ready", bus.table_ready, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out_data", bus.out_data, 0);
    tick();
  endtask

  task automatic pulse_load_start(input bit with_valid);
    bit will_accept;
    will_accept = !exp_ready || (exp_q.size() == 0);
    bus.load_start = 1'b1;
    bus.load_valid = with_valid;
    bus.load_data  = 16'hDEAD;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    if (will_accept) exp_ready = 1'b0;
  endtask

  // mode 0: base+i, mode 1: constant base, mode 2: random
  task automatic load_entries(input int n, input int mode, input logic [DW-1:0] base);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.load_valid = 1'b0;
        bus.load_data  = DW'($urandom);
        tick();
      end
      d = (mode == 0) ? base + DW'(i) : (mode == 1) ? base : DW'($urandom);
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      ref_mem[i]     = d;
      tick();
    end
    bus.load_valid = 1'b0;
    if (n == DEPTH) exp_ready = 1'b1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
    end
  endtask

  // Single lookup into an empty pipe, checking the 2-cycle latency.
  task automatic lookup_literal(input logic [NCH*AW-1:0] a, input logic [NCH*DW-1:0] expv,
                                input string nm);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_addr   = a;
    @(negedge clk);
    check({nm, "_in_ready"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_early_valid"}, bus.out_valid, 0);
    tick();
    @(negedge clk);
    check({nm, "_valid"}, bus.out_valid, 1);
    check({nm, "_data"}, bus.out_data, expv);
    tick();
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int acc;
    int out_before;
    bit held;
    logic [NCH*DW-1:0] held_data;
    logic [NCH*AW-1:0] addrs [3];
    bit ov [14];

    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.in_valid   = 1'b0;
    bus.in_addr    = '0;
    bus.out_ready  = 1'b1;

    // Scenario 1: ramp table, corner addresses
    do_reset();
    pulse_load_start(1'b0);
    load_entries(DEPTH, 0, 16'h3000);
    @(negedge clk);
    check("table_ready_after_load", bus.table_ready, 1);
    tick();
    check("model_pin_ramp", model_lookup(32'hFF7F_0100), 64'h30FF_307F_3001_3000);
    lookup_literal(32'hFF7F_0100, 64'h30FF_307F_3001_3000, "scn1");
    drain();

    // Scenario 2: 10 back-to-back requests
    for (int j = 0; j < 14; j++) begin
      bus.in_valid = (j < 10);
      bus.in_addr  = 32'($urandom);
      @(negedge clk);
      ov[j] = bus.out_valid;
      tick();
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 14; j++)
      check($sformatf("b2b_valid_%0d", j), ov[j], (j >= 2 && j < 12));
    drain();

    // Scenario 3: downstream stall with 3 requests offered
    out_before = n_out;
    for (int i = 0; i < 3; i++) addrs[i] = 32'($urandom);
    acc = 0;
    held = 1'b0;
    held_data = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = addrs[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      if (bus.out_valid) begin
        if (!held) begin
          held = 1'b1;
          held_data = bus.out_data;
        end else begin
          check("stall_out_data_stable", bus.out_data, held_data);
        end
      end
      tick();
      bus.in_valid = (acc < 3);
      if (acc < 3) bus.in_addr = addrs[acc];
    end
    check("stall_accepted", 32'(acc), 2);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && acc < 3; t++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    drain();
    check("stall_outputs", 32'(n_out - out_before), 3);

    // Scenario 4: partial load, restart (same-cycle beat ignored), constant reload
    pulse_load_start(1'b0);
    load_entries(100, 2, '0);
    pulse_load_start(1'b1);
    load_entries(DEPTH, 1, 16'h1BFC);
    tick();
    lookup_literal(32'($urandom), {4{16'h1BFC}}, "scn4");
    drain();

    // Scenario 5: reload ignored while S2 occupied, accepted after drain
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 32'($urandom);
    tick();
    bus.in_valid  = 1'b0;
    tick();
    pulse_load_start(1'b0);
    @(negedge clk);
    check("reload_ignored_ready", bus.table_ready, 1);
    tick();
    drain();
    pulse_load_start(1'b0);
    @(negedge clk);
    check("reload_after_drain_ready", bus.table_ready, 0);
    tick();
    load_entries(DEPTH, 2, '0);
    tick();

    // Scenario 6: reset in the middle of a load, requests held off until reload
    pulse_load_start(1'b0);
    load_entries(50, 0, 16'h5000);
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_addr  = 32'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_mid_in_ready", bus.in_ready, 0);
      check("rst_mid_out_valid", bus.out_valid, 0);
      tick();
    end
    pulse_load_start(1'b0);
    bus.in_valid = 1'b1;
    load_entries(DEPTH, 2, '0);

    // Random traffic with backpressure and stray load beats
    for (int c = 0; c < 400; c++) begin
      bus.in_valid   = ($urandom_range(3) != 0);
      bus.in_addr    = ($urandom_range(7) == 0) ? {4{8'($urandom)}} : 32'($urandom);
      bus.out_ready  = ($urandom_range(3) != 0);
      bus.load_valid = ($urandom_range(7) == 0);
      bus.load_data  = 16'($urandom);
      tick();
    end
    bus.load_valid = 1'b0;
    drain();
    check("final_pending", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
